// File: rtl/automata_trace_sequencer.sv
// Frames trace symbol streams into one LTL monitor automaton: re-arms it per trace, forwards
// symbols, and captures masked report hits into a valid/ready record with per-trace counters.
module automata_trace_sequencer #(
   parameter int unsigned NUM_REPORTS = 4,
   parameter int unsigned SYM_W       = 8,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [SYM_W-1:0]       s_symbol,
   input  logic                   s_last,
   input  logic                   abort,
   input  logic [NUM_REPORTS-1:0] cfg_report_mask,
   output logic                   a_run,
   output logic                   a_reset,
   output logic [SYM_W-1:0]       a_symbols,
   input  logic [NUM_REPORTS-1:0] a_report,
   output logic                   hit_valid,
   input  logic                   hit_ready,
   output logic [NUM_REPORTS-1:0] hit_vector,
   output logic [CNT_W-1:0]       hit_offset,
   output logic                   hit_overflow,
   output logic [CNT_W-1:0]       sym_count,
   output logic [CNT_W-1:0]       hit_count,
   output logic                   busy,
   output logic                   trace_done
);

   typedef enum logic [2:0] {StIdle, StArm, StStream, StDrain, StDone} state_e;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_e                   state_q, state_d;
   logic                     arm_st;
   logic                     run_q;
   logic [CNT_W-1:0]         idx_q;
   logic [CNT_W-1:0]         sym_count_q, sym_count_d;
   logic [CNT_W-1:0]         hit_count_q, hit_count_d;
   logic                     hit_valid_q, hit_valid_d;
   logic [NUM_REPORTS-1:0]   hit_vector_q, hit_vector_d;
   logic [CNT_W-1:0]         hit_offset_q, hit_offset_d;
   logic                     hit_overflow_q, hit_overflow_d;
   logic [NUM_REPORTS-1:0]   masked;
   logic                     hit;
   logic                     load;

   always_comb begin
      state_d    = state_q;
      s_ready    = 1'b0;
      arm_st     = 1'b0;
      trace_done = 1'b0;
      case (state_q)
         StIdle:   if (s_valid) state_d = StArm;
         StArm: begin
            arm_st  = 1'b1;
            state_d = StStream;
         end
         StStream: begin
            s_ready = 1'b1;
            if (s_valid && s_last) state_d = StDrain;
         end
         StDrain:  state_d = StDone;
         StDone: begin
            trace_done = 1'b1;
            state_d    = StIdle;
         end
         default:  state_d = StIdle;
      endcase
      if (abort && (state_q != StIdle)) state_d = StIdle;
   end

   // Automaton is held in reset while our own reset is asserted.
   assign a_reset   = arm_st | reset;
   assign a_symbols = reset ? '0 : s_symbol;
   assign a_run     = s_valid && s_ready;
   assign busy      = (state_q != StIdle);

   // Report for the symbol accepted last cycle is valid now.
   assign masked = a_report & cfg_report_mask;
   assign hit    = run_q && (masked != '0);
   assign load   = hit && (!hit_valid_q || hit_ready);

   always_comb begin
      sym_count_d    = sym_count_q;
      hit_count_d    = hit_count_q;
      hit_valid_d    = hit_valid_q;
      hit_vector_d   = hit_vector_q;
      hit_offset_d   = hit_offset_q;
      hit_overflow_d = hit_overflow_q;
      if (hit_ready) hit_valid_d = 1'b0;
      if (load) begin
         hit_valid_d  = 1'b1;
         hit_vector_d = masked;
         hit_offset_d = idx_q;
      end
      if (state_q == StArm) begin
         sym_count_d    = '0;
         hit_count_d    = '0;
         hit_overflow_d = 1'b0;
      end else begin
         if (a_run && (sym_count_q != CntMax)) sym_count_d = sym_count_q + CNT_W'(1);
         if (hit && (hit_count_q != CntMax)) hit_count_d = hit_count_q + CNT_W'(1);
         if (hit && !load) hit_overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         run_q          <= 1'b0;
         idx_q          <= '0;
         sym_count_q    <= '0;
         hit_count_q    <= '0;
         hit_valid_q    <= 1'b0;
         hit_vector_q   <= '0;
         hit_offset_q   <= '0;
         hit_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         run_q          <= a_run;
         idx_q          <= sym_count_q;
         sym_count_q    <= sym_count_d;
         hit_count_q    <= hit_count_d;
         hit_valid_q    <= hit_valid_d;
         hit_vector_q   <= hit_vector_d;
         hit_offset_q   <= hit_offset_d;
         hit_overflow_q <= hit_overflow_d;
      end
   end

   assign hit_valid    = hit_valid_q;
   assign hit_vector   = hit_vector_q;
   assign hit_offset   = hit_offset_q;
   assign hit_overflow = hit_overflow_q;
   assign sym_count    = sym_count_q;
   assign hit_count    = hit_count_q;

endmodule

// File: tb/tb_automata_trace_sequencer.sv
// Scoreboard bench for automata_trace_sequencer with a behavioural one-cycle-latency automaton.
module tb_automata_trace_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid, s_ready, s_last, abort;
   logic [7:0]  s_symbol;
   logic [3:0]  cfg_report_mask;
   logic        a_run, a_reset;
   logic [7:0]  a_symbols;
   logic [3:0]  a_report;
   logic        hit_valid, hit_ready, hit_overflow;
   logic [3:0]  hit_vector;
   logic [15:0] hit_offset, sym_count, hit_count;
   logic        busy, trace_done;

   automata_trace_sequencer #(.NUM_REPORTS(4), .SYM_W(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_symbol(s_symbol),
      .s_last(s_last), .abort(abort), .cfg_report_mask(cfg_report_mask), .a_run(a_run),
      .a_reset(a_reset), .a_symbols(a_symbols), .a_report(a_report), .hit_valid(hit_valid),
      .hit_ready(hit_ready), .hit_vector(hit_vector), .hit_offset(hit_offset),
      .hit_overflow(hit_overflow), .sym_count(sym_count), .hit_count(hit_count), .busy(busy),
      .trace_done(trace_done)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_acc = 0;
   logic [3:0]  rep_map [256];
   logic [19:0] exp_hits[$];   // {vector, offset}
   logic [31:0] exp_done[$];   // {sym_count, hit_count}

   // Automaton model: report appears the cycle after a run cycle.
   always @(posedge clk or posedge reset) begin
      if (reset) a_report <= '0;
      else       a_report <= a_run ? rep_map[a_symbols] : 4'h0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Hit record monitor.
   always @(negedge clk) begin
      if (!reset && hit_valid && hit_ready) begin
         if (exp_hits.size() == 0) begin
            chk("unexpected_hit", {12'h0, hit_vector, hit_offset}, 32'h0);
         end else begin
            logic [19:0] e;
            e = exp_hits.pop_front();
            chk("hit_vector", {28'h0, hit_vector}, {28'h0, e[19:16]});
            chk("hit_offset", {16'h0, hit_offset}, {16'h0, e[15:0]});
         end
      end
   end

   // Trace completion monitor.
   always @(negedge clk) begin
      if (!reset && trace_done) begin
         if (exp_done.size() == 0) begin
            chk("unexpected_trace_done", 32'd1, 32'd0);
         end else begin
            logic [31:0] e;
            e = exp_done.pop_front();
            chk("done_sym_count", {16'h0, sym_count}, {16'h0, e[31:16]});
            chk("done_hit_count", {16'h0, hit_count}, {16'h0, e[15:0]});
            chk("done_latency", cyc - last_acc, 32'd2);
         end
      end
   end

   task automatic send_sym(input logic [7:0] sym, input bit last, input bit first);
      bit   got = 0;
      int   n = 0;
      logic prev_ar = 1'b0;
      s_valid  = 1'b1;
      s_symbol = sym;
      s_last   = last;
      while (!got && n < 20) begin
         @(negedge clk);
         if (s_ready) got = 1;
         else begin
            prev_ar = a_reset;
            n++;
         end
      end
      if (!got) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         if (first) begin
            chk("a_reset_before_sym0", {31'h0, prev_ar}, 32'd1);
            chk("a_reset_at_sym0", {31'h0, a_reset}, 32'd0);
            chk("sym_count_restart", {16'h0, sym_count}, 32'd0);
         end
         chk("a_symbols", {24'h0, a_symbols}, {24'h0, sym});
         last_acc = cyc;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || trace_done) && n < 20);
      if (n >= 20) chk("idle_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic clear_map();
      for (int i = 0; i < 256; i++) rep_map[i] = 4'h0;
   endtask

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; abort = 1'b0; s_symbol = 8'h00;
      hit_ready = 1'b1; cfg_report_mask = 4'hF;
      clear_map();
      #1;
      chk("rst_a_reset", {31'h0, a_reset}, 32'd1);
      chk("rst_s_ready", {31'h0, s_ready}, 32'd0);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_hit_valid", {31'h0, hit_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_a_reset", {31'h0, a_reset}, 32'd0);
      @(posedge clk); #1;

      // Basic trace, one hit on symbol 1.
      rep_map[8'h10] = 4'b0010;
      exp_hits.push_back({4'b0010, 16'd1});
      exp_done.push_back({16'd4, 16'd1});
      send_sym(8'h00, 0, 1); send_sym(8'h10, 0, 0); send_sym(8'h20, 0, 0); send_sym(8'h05, 1, 0);
      wait_idle();
      chk("hold_sym_count", {16'h0, sym_count}, 32'd4);
      chk("hold_hit_count", {16'h0, hit_count}, 32'd1);

      // Same trace with a 3-cycle stall after symbol 1.
      exp_hits.push_back({4'b0010, 16'd1});
      exp_done.push_back({16'd4, 16'd1});
      send_sym(8'h00, 0, 1); send_sym(8'h10, 0, 0);
      repeat (3) begin
         @(negedge clk);
         chk("gap_a_run", {31'h0, a_run}, 32'd0);
         chk("gap_sym_count", {16'h0, sym_count}, 32'd2);
         @(posedge clk); #1;
      end
      send_sym(8'h20, 0, 0); send_sym(8'h05, 1, 0);
      wait_idle();

      // Back-pressure: first hit held, later hits dropped.
      hit_ready = 1'b0;
      rep_map[8'h00] = 4'b0001; rep_map[8'h20] = 4'b0100;
      exp_done.push_back({16'd4, 16'd3});
      send_sym(8'h00, 0, 1); send_sym(8'h10, 0, 0); send_sym(8'h20, 0, 0); send_sym(8'h05, 1, 0);
      wait_idle();
      chk("bp_hit_valid", {31'h0, hit_valid}, 32'd1);
      chk("bp_hit_offset", {16'h0, hit_offset}, 32'd0);
      chk("bp_hit_vector", {28'h0, hit_vector}, 32'd1);
      chk("bp_overflow", {31'h0, hit_overflow}, 32'd1);
      exp_hits.push_back({4'b0001, 16'd0});
      hit_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hit_cleared", {31'h0, hit_valid}, 32'd0);
      chk("bp_overflow_sticky", {31'h0, hit_overflow}, 32'd1);
      @(posedge clk); #1;

      // Masked-out report bit.
      clear_map();
      rep_map[8'h20] = 4'b0100;
      cfg_report_mask = 4'b0001;
      exp_done.push_back({16'd4, 16'd0});
      send_sym(8'h00, 0, 1); send_sym(8'h10, 0, 0); send_sym(8'h20, 0, 0); send_sym(8'h05, 1, 0);
      wait_idle();
      chk("mask_hit_valid", {31'h0, hit_valid}, 32'd0);
      chk("mask_overflow_cleared", {31'h0, hit_overflow}, 32'd0);

      // Abort after two symbols, then a fresh 2-symbol trace.
      clear_map();
      cfg_report_mask = 4'hF;
      send_sym(8'h00, 0, 1); send_sym(8'h10, 0, 0);
      abort = 1'b1;
      @(negedge clk);
      chk("abort_busy_before", {31'h0, busy}, 32'd1);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", {31'h0, busy}, 32'd0);
      chk("abort_no_done", {31'h0, trace_done}, 32'd0);
      @(posedge clk); #1;
      exp_done.push_back({16'd2, 16'd0});
      send_sym(8'h30, 0, 1); send_sym(8'h31, 1, 0);
      wait_idle();

      // Async reset mid-stream with a pending hit record.
      hit_ready = 1'b0;
      rep_map[8'h00] = 4'b0001;
      send_sym(8'h00, 0, 1); send_sym(8'h10, 0, 0);
      chk("pre_rst_hit_valid", {31'h0, hit_valid}, 32'd1);
      s_valid = 1'b1; s_symbol = 8'hAB;
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", {31'h0, busy}, 32'd0);
      chk("arst_s_ready", {31'h0, s_ready}, 32'd0);
      chk("arst_a_run", {31'h0, a_run}, 32'd0);
      chk("arst_a_reset", {31'h0, a_reset}, 32'd1);
      chk("arst_a_symbols", {24'h0, a_symbols}, 32'd0);
      chk("arst_sym_count", {16'h0, sym_count}, 32'd0);
      chk("arst_hit_count", {16'h0, hit_count}, 32'd0);
      chk("arst_hit_valid", {31'h0, hit_valid}, 32'd0);
      chk("arst_overflow", {31'h0, hit_overflow}, 32'd0);
      chk("arst_trace_done", {31'h0, trace_done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("arst_a_reset_held", {31'h0, a_reset}, 32'd1);
      s_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      chk("hit_queue_drained", exp_hits.size(), 32'd0);
      chk("done_queue_drained", exp_done.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/automata_trace_sequencer.md
Name: automata_trace_sequencer

Overview:
- Sequences one generated LTL monitor automaton (8-bit symbols, NUM_REPORTS report outputs) over framed trace streams.
- Per trace: pulses the automaton's reset so start_of_data fires exactly on the first symbol, then streams symbols with run.
- Captures masked report hits into a valid/ready hit interface and keeps per-trace counters.
- Sits between the trace symbol source and an Automata_* instance inside a monitor cluster.

Parameters:
NUM_REPORTS, 4, width of report vector from the automaton
SYM_W, 8, symbol width
CNT_W, 16, width of symbol and hit counters (saturating)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_valid  in  1  symbol available
s_ready  out  1  symbol accepted when s_valid&&s_ready
s_symbol  in  SYM_W  trace symbol
s_last  in  1  marks final symbol of a trace
abort  in  1  abandon current trace
cfg_report_mask  in  NUM_REPORTS  1 = report bit counted as hit
a_run  out  1  automaton run
a_reset  out  1  automaton reset
a_symbols  out  SYM_W  automaton symbol input
a_report  in  NUM_REPORTS  automaton report outputs
hit_valid  out  1  hit record pending
hit_ready  in  1  hit record consumed
hit_vector  out  NUM_REPORTS  masked report bits of hit
hit_offset  out  CNT_W  0-based symbol index that caused hit
hit_overflow  out  1  sticky: hit dropped while hit_valid pending
sym_count  out  CNT_W  symbols accepted this trace
hit_count  out  CNT_W  hits detected this trace (incl. dropped)
busy  out  1  state != IDLE
trace_done  out  1  one-cycle pulse at end of trace

Behaviour:
- Reset (async): state IDLE; a_reset=1, a_run=0, a_symbols=0, s_ready=0, hit_valid=0, hit_vector=0, hit_offset=0, hit_overflow=0, sym_count=0, hit_count=0, busy=0, trace_done=0.
- a_symbols = s_symbol combinationally; a_run = s_valid&&s_ready.
- States: IDLE, ARM, STREAM, DRAIN, DONE.
- IDLE: a_reset=0, s_ready=0. On s_valid -> ARM.
- ARM, 1 cycle: a_reset=1, s_ready=0; clear sym_count, hit_count, hit_overflow; -> STREAM.
- STREAM: a_reset=0, s_ready=1.
  - First STREAM cycle is the automaton's start_of_data cycle. The source holds s_valid high from IDLE detection onward, so symbol 0 is accepted there.
  - Each accept increments sym_count (saturates at 2^CNT_W-1).
  - Stalls (s_valid=0) drive a_run=0; automaton state holds.
  - Accept with s_last=1 -> DRAIN.
- Report latency: the report for a symbol accepted in cycle t is sampled from a_report in cycle t+1, only if t had a_run=1.
  - Hit = (a_report & cfg_report_mask) != 0 at a sample point.
  - Each hit increments hit_count (saturating).
  - Hit record: if hit_valid=0, or hit_valid&&hit_ready in the same cycle, load hit_vector = masked report and hit_offset = index of the causing symbol; hit_valid=1 next cycle.
  - Otherwise the hit is dropped and hit_overflow is set (sticky until next ARM or reset).
- hit_valid clears on hit_ready unless reloaded the same cycle. Hit records are not cleared by DONE and persist across traces until consumed.
- DRAIN, 1 cycle: s_ready=0; samples the report of the last symbol; -> DONE.
- DONE, 1 cycle: trace_done=1; sym_count and hit_count hold final values until next ARM; -> IDLE.
- abort, any non-IDLE state: next cycle IDLE, no trace_done; pending hit record kept; automaton re-armed by next ARM. abort in IDLE is ignored. abort has priority over s_last.
- s_last on symbol 0 is legal: a 1-symbol trace, ARM->STREAM->DRAIN->DONE.

Test Plan:
- Mask=4'b1111; trace 0x00,0x10,0x20,0x05 (last), automaton report bit1 fires only on symbol 1, hit_ready=1:
  - a_reset high exactly 1 cycle, immediately before symbol 0 accept.
  - One hit: vector 4'b0010, offset 1.
  - sym_count=4, hit_count=1, trace_done pulses 2 cycles after the last accept.
- Same trace, s_valid low for 3 cycles between symbols 1 and 2: a_run low during the gap, counts unchanged, identical hit result.
- hit_ready=0, reports firing on symbols 0, 1 and 2:
  - hit_valid holds offset 0.
  - hit_overflow=1, hit_count=3.
  - Asserting hit_ready then clears hit_valid.
- Mask=4'b0001, report bit2 firing: no hit_valid, hit_count=0.
- abort asserted after 2 symbols:
  - IDLE next cycle, no trace_done.
  - Next trace re-pulses a_reset; sym_count restarts at 0.
- Async reset mid-STREAM: all outputs at reset values immediately, no clock needed; a_reset=1 while reset held.
